// File: rtl/cell_painter_if.sv
// rtl/cell_painter_if.sv - request and LCD bus signals between scanner, painter and panel
interface cell_painter_if;
    logic       en_update;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;
    logic       cmd_done;
    logic       busy;
    logic       lcd_cs_n;
    logic       lcd_dc;
    logic       lcd_wr_n;
    logic [7:0] lcd_data;

    modport master (
        output en_update, x, y, obj_code,
        input  cmd_done, busy, lcd_cs_n, lcd_dc, lcd_wr_n, lcd_data
    );

    modport slave (
        input  en_update, x, y, obj_code,
        output cmd_done, busy, lcd_cs_n, lcd_dc, lcd_wr_n, lcd_data
    );
endinterface

// File: rtl/cell_painter.sv
// rtl/cell_painter.sv - paints one grid cell as a filled RGB565 tile over an 8080 bus
module cell_painter #(
    parameter int          CELL_PX    = 20,
    parameter logic [15:0] COL_EMPTY  = 16'h0000,
    parameter logic [15:0] COL_HEAD   = 16'h07E0,
    parameter logic [15:0] COL_BODY   = 16'h03E0,
    parameter logic [15:0] COL_APPLE  = 16'hF800,
    parameter logic [15:0] COL_BORDER = 16'hFFFF,
    parameter logic [15:0] COL_OTHER  = 16'hF81F
) (
    input  logic          clk,
    input  logic          nrst,
    cell_painter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CMD_CA, ARG_CA, CMD_PA, ARG_PA, CMD_WR, PIX, DONE
    } state_t;

    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_PASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;
    localparam logic [3:0] ROW_MAX  = 4'd11;
    localparam logic [8:0] PIX_LAST = 9'(CELL_PX * CELL_PX - 1);

    state_t      state;
    logic [3:0]  cell_x;
    logic [3:0]  cell_y;
    logic [2:0]  cell_obj;
    logic        armed;
    logic        phase;     // 0: strobe low, 1: strobe high (byte latched by panel)
    logic        half;      // 0: colour high byte, 1: colour low byte
    logic [1:0]  idx;       // argument byte index within CASET/PASET
    logic [8:0]  pix;

    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] colour;

    // Window corners and tile colour derived from the latched cell
    always_comb begin
        x0 = 9'(cell_x) * 9'(CELL_PX);
        x1 = x0 + 9'(CELL_PX - 1);
        y0 = 9'(cell_y) * 9'(CELL_PX);
        y1 = y0 + 9'(CELL_PX - 1);
        case (cell_obj)
            3'b000:  colour = COL_EMPTY;
            3'b001:  colour = COL_HEAD;
            3'b010:  colour = COL_BODY;
            3'b011:  colour = COL_APPLE;
            3'b100:  colour = COL_BORDER;
            default: colour = COL_OTHER;
        endcase
    end

    // 16-bit start/end pair sent MSB first; coordinates fit in 9 bits
    function automatic logic [7:0] arg_byte(input logic [8:0] a, input logic [8:0] b,
                                            input logic [1:0] i);
        case (i)
            2'd0:    arg_byte = {7'b0, a[8]};
            2'd1:    arg_byte = a[7:0];
            2'd2:    arg_byte = {7'b0, b[8]};
            default: arg_byte = b[7:0];
        endcase
    endfunction

    // Transaction sequencer; every bus output is registered here
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            armed        <= 1'b1;
            cell_x       <= '0;
            cell_y       <= '0;
            cell_obj     <= '0;
            phase        <= 1'b0;
            half         <= 1'b0;
            idx          <= '0;
            pix          <= '0;
            bus.cmd_done <= 1'b0;
            bus.busy     <= 1'b0;
            bus.lcd_cs_n <= 1'b1;
            bus.lcd_wr_n <= 1'b1;
            bus.lcd_dc   <= 1'b0;
            bus.lcd_data <= '0;
        end else begin
            // A request held across completion must drop before it can re-arm
            if (bus.cmd_done)
                armed <= 1'b0;
            else if (!bus.en_update)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    bus.cmd_done <= 1'b0;
                    if (bus.en_update && armed) begin
                        cell_x   <= bus.x;
                        cell_y   <= bus.y;
                        cell_obj <= bus.obj_code;
                        bus.busy <= 1'b1;
                        if (bus.y > ROW_MAX) begin
                            state <= DONE;
                        end else begin
                            state        <= CMD_CA;
                            phase        <= 1'b0;
                            bus.lcd_cs_n <= 1'b0;
                            bus.lcd_wr_n <= 1'b0;
                            bus.lcd_dc   <= 1'b0;
                            bus.lcd_data <= OP_CASET;
                        end
                    end
                end

                DONE: begin
                    // Rejected cells arrive here with cmd_done still low
                    if (bus.cmd_done) begin
                        state        <= IDLE;
                        bus.cmd_done <= 1'b0;
                        bus.busy     <= 1'b0;
                    end else begin
                        bus.cmd_done <= 1'b1;
                    end
                end

                default: begin
                    if (!phase) begin
                        phase        <= 1'b1;
                        bus.lcd_wr_n <= 1'b1;
                    end else begin
                        phase        <= 1'b0;
                        bus.lcd_wr_n <= 1'b0;
                        case (state)
                            CMD_CA: begin
                                state        <= ARG_CA;
                                idx          <= 2'd0;
                                bus.lcd_dc   <= 1'b1;
                                bus.lcd_data <= arg_byte(x0, x1, 2'd0);
                            end
                            ARG_CA: begin
                                if (idx == 2'd3) begin
                                    state        <= CMD_PA;
                                    bus.lcd_dc   <= 1'b0;
                                    bus.lcd_data <= OP_PASET;
                                end else begin
                                    idx          <= idx + 2'd1;
                                    bus.lcd_data <= arg_byte(x0, x1, idx + 2'd1);
                                end
                            end
                            CMD_PA: begin
                                state        <= ARG_PA;
                                idx          <= 2'd0;
                                bus.lcd_dc   <= 1'b1;
                                bus.lcd_data <= arg_byte(y0, y1, 2'd0);
                            end
                            ARG_PA: begin
                                if (idx == 2'd3) begin
                                    state        <= CMD_WR;
                                    bus.lcd_dc   <= 1'b0;
                                    bus.lcd_data <= OP_RAMWR;
                                end else begin
                                    idx          <= idx + 2'd1;
                                    bus.lcd_data <= arg_byte(y0, y1, idx + 2'd1);
                                end
                            end
                            CMD_WR: begin
                                state        <= PIX;
                                pix          <= '0;
                                half         <= 1'b0;
                                bus.lcd_dc   <= 1'b1;
                                bus.lcd_data <= colour[15:8];
                            end
                            PIX: begin
                                if (!half) begin
                                    half         <= 1'b1;
                                    bus.lcd_data <= colour[7:0];
                                end else if (pix == PIX_LAST) begin
                                    state        <= DONE;
                                    bus.cmd_done <= 1'b1;
                                    bus.lcd_cs_n <= 1'b1;
                                    bus.lcd_wr_n <= 1'b1;
                                    bus.lcd_dc   <= 1'b0;
                                    bus.lcd_data <= '0;
                                end else begin
                                    pix          <= pix + 9'd1;
                                    half         <= 1'b0;
                                    bus.lcd_data <= colour[15:8];
                                end
                            end
                            default: begin
                                state        <= IDLE;
                                bus.lcd_cs_n <= 1'b1;
                                bus.lcd_wr_n <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cell_painter.sv
// tb/tb_cell_painter.sv - randomized bench for cell_painter against a byte-stream model
module tb_cell_painter;
    logic clk;
    logic nrst;
    int   vectors;
    int   miscompares;
    int   cs_low;
    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];

    cell_painter_if bus();

    cell_painter dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte the panel would latch, tagged with dc
    always @(negedge clk) begin
        if (nrst && !bus.lcd_cs_n) begin
            cs_low++;
            if (!bus.lcd_wr_n)
                cap_q.push_back({bus.lcd_dc, bus.lcd_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int colour_of(input int o);
        case (o)
            0:       return 'h0000;
            1:       return 'h07E0;
            2:       return 'h03E0;
            3:       return 'hF800;
            4:       return 'hFFFF;
            default: return 'hF81F;
        endcase
    endfunction

    function automatic void push_word(input int w);
        exp_q.push_back({1'b1, 8'((w >> 8) & 255)});
        exp_q.push_back({1'b1, 8'(w & 255)});
    endfunction

    function automatic void build_expected(input int px, input int py, input int po);
        int c;
        exp_q.delete();
        if (py > 11) return;
        exp_q.push_back({1'b0, 8'h2A});
        push_word(px * 20);
        push_word(px * 20 + 19);
        exp_q.push_back({1'b0, 8'h2B});
        push_word(py * 20);
        push_word(py * 20 + 19);
        exp_q.push_back({1'b0, 8'h2C});
        c = colour_of(po);
        for (int i = 0; i < 400; i++) push_word(c);
    endfunction

    task automatic compare_stream(input string tag);
        int errs;
        check({tag, "_bytes"}, cap_q.size(), exp_q.size());
        errs = 0;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            if (cap_q[i] !== exp_q[i] && errs < 4) begin
                errs++;
                check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
            end else if (cap_q[i] === exp_q[i] && (i % 100) == 0) begin
                check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic paint(input int px, input int py, input int po,
                         input bit hold, input bit scramble);
        int lat;
        @(negedge clk);
        bus.en_update = 1'b0;
        @(negedge clk);
        bus.x = 4'(px);
        bus.y = 4'(py);
        bus.obj_code = 3'(po);
        bus.en_update = 1'b1;
        build_expected(px, py, po);
        cap_q.delete();
        cs_low = 0;
        @(posedge clk);
        @(negedge clk);
        check("busy_accept", bus.busy, 1);
        if (scramble) begin
            bus.x = 4'($urandom_range(15));
            bus.y = 4'($urandom_range(11));
            bus.obj_code = 3'($urandom_range(7));
        end
        if (!hold) bus.en_update = 1'b0;
        lat = 0;
        while (!bus.cmd_done && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, (py > 11) ? 1 : 1622);
        check("busy_done", bus.busy, 1);
        check("cs_done", bus.lcd_cs_n, 1);
        @(negedge clk);
        check("pulse_width", bus.cmd_done, 0);
        check("busy_idle", bus.busy, 0);
        if (py > 11) check("cs_never_low", cs_low, 0);
        compare_stream("stream");
    endtask

    initial begin
        int lat;
        vectors = 0;
        miscompares = 0;
        cs_low = 0;
        nrst = 1'b0;
        bus.en_update = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.obj_code = '0;
        #12;
        check("rst_cs_n", bus.lcd_cs_n, 1);
        check("rst_wr_n", bus.lcd_wr_n, 1);
        check("rst_dc", bus.lcd_dc, 0);
        check("rst_data", bus.lcd_data, 0);
        check("rst_done", bus.cmd_done, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        nrst = 1'b1;

        paint(0, 0, 0, 1'b0, 1'b0);
        paint(15, 11, 3, 1'b0, 1'b0);
        paint(15, 11, 6, 1'b0, 1'b0);

        // Held request must not repaint; then drop/raise with inputs scrambled mid-paint
        paint(7, 5, 1, 1'b1, 1'b0);
        cs_low = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("held_busy", bus.busy, 0);
        end
        check("held_cs", cs_low, 0);
        paint(9, 3, 2, 1'b0, 1'b1);

        paint(4, 12, 4, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            paint($urandom_range(15), $urandom_range(11), $urandom_range(7), 1'b0, 1'b1);
        paint($urandom_range(15), $urandom_range(15, 12), $urandom_range(7), 1'b0, 1'b0);

        // Reset during pixel byte 100
        @(negedge clk);
        bus.en_update = 1'b0;
        @(negedge clk);
        bus.x = 4'd3;
        bus.y = 4'd2;
        bus.obj_code = 3'd4;
        bus.en_update = 1'b1;
        cap_q.delete();
        @(negedge clk);
        bus.en_update = 1'b0;
        lat = 0;
        while (cap_q.size() < 112 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("reach_pix100", cap_q.size(), 112);
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst_cs_n", bus.lcd_cs_n, 1);
        check("mid_rst_wr_n", bus.lcd_wr_n, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.cmd_done, 0);
        check("mid_rst_dc", bus.lcd_dc, 0);
        check("mid_rst_data", bus.lcd_data, 0);
        @(negedge clk);
        nrst = 1'b1;
        paint(3, 2, 4, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
